fsm_seq_tx: RTL and testbench
=============================

Name: fsm_seq_tx

Overview:
Serial bit-stream transmitter that produces framed sequences for the team's FSM sequence-detector designs.
- Accepts one parallel word per valid/ready handshake and serialises it: start bit, DATA_W data bits, stop bit.
- Each bit is held for a programmable number of clock cycles.
- Sits upstream of the detector, driving its serial input pin from the board or an on-chip stimulus source.

Parameters:
DATA_W, 8, data bits per frame (>=1)
DIV_W, 8, width of bit-period field
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word (IDLE)
bit_period  input  DIV_W  cycles per serial bit; 0 treated as 1
ser_out  output  1  serial line; idle level 1
busy  output  1  frame in progress
done  output  1  one-cycle pulse on last cycle of stop bit

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; ser_out=1, in_ready=1, busy=0, done=0.
  - Shift register, bit counter and period counter all cleared.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - ser_out=1, in_ready=1.
  - On in_valid&&in_ready at edge N: latch in_data into shift register, latch P=max(bit_period,1), go to START.
- START: ser_out=0 from cycle N+1 for P cycles, then DATA.
- DATA:
  - Presents DATA_W bits, each for exactly P cycles.
  - Bit order: bit0 first when MSB_FIRST=0, bit DATA_W-1 first otherwise.
  - After the last bit, go to STOP.
- STOP:
  - ser_out=1 for P cycles.
  - done=1 on the final STOP cycle only.
  - Then IDLE; in_ready=1 on the following cycle.
- Frame length: exactly (DATA_W+2)*P cycles of busy=1, measured from acceptance to done inclusive.
- Gap between frames: minimum 1 idle cycle (ser_out=1), since the back-to-back accept happens in the IDLE cycle after done.
- Output signals:
  - in_ready = (state==IDLE).
  - busy = !in_ready.
  - ser_out is registered, with no combinational path from inputs.
- Ignored during a frame:
  - in_valid is ignored while busy.
  - Changes to in_data or bit_period mid-frame do not affect the current frame.
- Period counter: DIV_W bits, counts P-1 down to 0 and reloads on each bit boundary; no wrap-around beyond P.
- Bit counter: width clog2(DATA_W+1); saturates nowhere, reloaded on entry to DATA.
- Reset mid-frame: ser_out returns to 1 immediately (async), frame abandoned, no done pulse.
- Reset held with in_valid=1: nothing accepted until the first edge after rst deasserts.

Decomposition:
- Shared package fsm_seq_pkg:
  - state enum (IDLE/START/DATA/STOP).
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One natural sub-module: fsm_seq_bit_timer, a DIV_W-bit loadable down-counter.
  - Inputs: load, period.
  - Output: tick, asserted on the last cycle of each bit.
  - Instantiated once.

Test Plan:
1. P=1, MSB_FIRST=0, send 0xA5 -> ser_out after accept: 0,1,0,1,0,0,1,0,1,1 (10 cycles); done high on cycle 10; in_ready high on cycle 11.
2. bit_period=3, send 0x00 -> ser_out low for 27 cycles, then high for 3; busy high exactly 30 cycles; one done pulse.
3. bit_period=0, send 0xFF -> identical timing to P=1: one 0 followed by nine 1s, 10-cycle frame.
4. MSB_FIRST=1, P=2, send 0x80 -> 0,0 then 1,1 then fourteen 0s then 1,1; total 20 cycles.
5. in_valid held high with new data 0x3C after accepting 0x5A; change bit_period mid-frame -> first frame sends 0x5A at the original P; 0x3C is accepted in the IDLE cycle after done and sent at the new P.
6. Assert rst during DATA bit 4 -> ser_out=1 in the same cycle, no done pulse, in_ready=1 after release; the next frame is transmitted correctly.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// -----------------------------------------------------------------------------
// fsm_seq_pkg
// Shared types and line levels for the framed serial transmitter.
//   state_t     : transmitter FSM states
//   IDLE_LEVEL  : level driven on the line between frames
//   START_LEVEL : level of the start bit
//   STOP_LEVEL  : level of the stop bit
// -----------------------------------------------------------------------------
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/fsm_seq_bit_timer.sv
// -----------------------------------------------------------------------------
// fsm_seq_bit_timer
// Loadable down-counter that times one serial bit.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   load     : reload the counter with period-1 (period must be >= 1)
//   period   : cycles per bit
//   tick     : counter at zero, i.e. last cycle of the current bit
//   pre_tick : counter at one, i.e. the next cycle is the last of the bit
// -----------------------------------------------------------------------------
module fsm_seq_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             tick,
  output logic             pre_tick
);

  logic [DIV_W-1:0] r_cnt;

  // Holds at zero once expired so it never wraps past the loaded period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= period - DIV_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign tick     = (r_cnt == '0);
  assign pre_tick = (r_cnt == DIV_W'(1));

endmodule

// File: rtl/fsm_seq_tx.sv
// -----------------------------------------------------------------------------
// fsm_seq_tx
// Serialises one parallel word per valid/ready handshake as
// start bit, DATA_W data bits, stop bit; each bit held for P cycles,
// P = max(bit_period, 1) sampled at acceptance.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   in_data    : word to transmit
//   in_valid   : in_data is valid
//   in_ready   : block is idle and accepts a word
//   bit_period : cycles per serial bit (0 behaves as 1)
//   ser_out    : registered serial line, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse on the last cycle of the stop bit
//
// state | meaning
// IDLE  | line high, waiting for in_valid
// START | start bit on the line for P cycles
// DATA  | DATA_W data bits, P cycles each
// STOP  | stop bit for P cycles, done on the final cycle
// -----------------------------------------------------------------------------
module fsm_seq_tx
  import fsm_seq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV_W-1:0]  bit_period,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic [DIV_W-1:0]  r_p;
  logic [BW-1:0]     r_bits;
  logic              r_ser;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_pre_tick;
  logic              w_accept;
  logic              w_load;
  logic [DIV_W-1:0]  w_p_in;
  logic [DIV_W-1:0]  w_period;
  logic [DATA_W-1:0] w_sh_next;
  logic              w_first_bit;
  logic              w_next_bit;

  assign w_p_in   = (bit_period == '0) ? DIV_W'(1) : bit_period;
  assign w_accept = (r_state == IDLE) && in_valid;

  // Reload at acceptance and at every bit boundary except the end of STOP.
  assign w_load   = w_accept || (w_tick && (r_state == START || r_state == DATA));
  assign w_period = w_accept ? w_p_in : r_p;

  assign w_sh_next   = MSB_FIRST ? (r_sh << 1) : (r_sh >> 1);
  assign w_first_bit = MSB_FIRST ? r_sh[DATA_W-1] : r_sh[0];
  assign w_next_bit  = MSB_FIRST ? w_sh_next[DATA_W-1] : w_sh_next[0];

  fsm_seq_bit_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .period   (w_period),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_p     <= '0;
      r_bits  <= '0;
      r_ser   <= IDLE_LEVEL;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ser <= IDLE_LEVEL;
          if (in_valid) begin
            r_sh    <= in_data;
            r_p     <= w_p_in;
            r_state <= START;
            r_ser   <= START_LEVEL;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_bits  <= BW'(DATA_W);
            r_ser   <= w_first_bit;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bits == BW'(1)) begin
              r_state <= STOP;
              r_ser   <= STOP_LEVEL;
              // With P=1 the first STOP cycle is also the last.
              if (r_p == DIV_W'(1)) begin
                r_done <= 1'b1;
              end
            end else begin
              r_sh   <= w_sh_next;
              r_bits <= r_bits - BW'(1);
              r_ser  <= w_next_bit;
            end
          end
        end
        STOP: begin
          // done is registered, so it is raised one cycle ahead of the tick.
          if (w_pre_tick) begin
            r_done <= 1'b1;
          end
          if (w_tick) begin
            r_state <= IDLE;
            r_ser   <= IDLE_LEVEL;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ser   <= IDLE_LEVEL;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign busy     = r_busy;
  assign ser_out  = r_ser;
  assign done     = r_done;

endmodule

// File: tb/tb_fsm_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_fsm_seq_tx
// Two transmitters (LSB-first and MSB-first) share the same inputs; every
// frame is compared cycle by cycle against a model that derives each line
// level from the frame position: bit slot = cycle / P.
// -----------------------------------------------------------------------------
module tb_fsm_seq_tx;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DIV_W-1:0]  bit_period;

  logic in_ready_l, ser_l, busy_l, done_l;
  logic in_ready_m, ser_m, busy_m, done_m;

  int checks;
  int errors;

  fsm_seq_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready_l),
    .bit_period (bit_period),
    .ser_out    (ser_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  fsm_seq_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .bit_period (bit_period),
    .ser_out    (ser_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for cycle k (0-based after acceptance) of a frame.
  function automatic logic model_bit(input logic [DATA_W-1:0] d, input int p,
                                     input int k, input bit msb);
    int slot;
    int j;
    slot = k / p;
    if (slot == 0) return 1'b0;
    if (slot >= DATA_W + 1) return 1'b1;
    j = slot - 1;
    return msb ? d[DATA_W-1-j] : d[j];
  endfunction

  function automatic int eff_p(input logic [DIV_W-1:0] bp);
    return (bp == 0) ? 1 : int'(bp);
  endfunction

  // Drive one word at negedge; returns after the accepting posedge (+1).
  task automatic accept(input logic [DATA_W-1:0] d, input logic [DIV_W-1:0] bp);
    @(negedge clk);
    in_data    = d;
    bit_period = bp;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sample every cycle of a frame that was accepted at the last posedge.
  task automatic check_frame(input string name, input logic [DATA_W-1:0] d,
                             input int p);
    int len;
    logic exp_l, exp_m, exp_done;
    len = (DATA_W + 2) * p;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      exp_l    = model_bit(d, p, k, 1'b0);
      exp_m    = model_bit(d, p, k, 1'b1);
      exp_done = (k == len - 1);
      checks++;
      if (ser_l !== exp_l || ser_m !== exp_m) begin
        errors++;
        $display("FAIL %s ser cyc=%0d got lsb=%b msb=%b want lsb=%b msb=%b",
                 name, k, ser_l, ser_m, exp_l, exp_m);
      end
      checks++;
      if (busy_l !== 1'b1 || busy_m !== 1'b1 || in_ready_l !== 1'b0 || in_ready_m !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got busy=%b%b ready=%b%b want busy=11 ready=00",
                 name, k, busy_l, busy_m, in_ready_l, in_ready_m);
      end
      checks++;
      if (done_l !== exp_done || done_m !== exp_done) begin
        errors++;
        $display("FAIL %s done cyc=%0d got %b%b want %b%b",
                 name, k, done_l, done_m, exp_done, exp_done);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1 || busy_l !== 1'b0 || busy_m !== 1'b0 ||
        ser_l !== 1'b1 || ser_m !== 1'b1 || done_l !== 1'b0 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got ready=%b%b busy=%b%b ser=%b%b done=%b%b want ready=11 busy=00 ser=11 done=00",
               name, in_ready_l, in_ready_m, busy_l, busy_m, ser_l, ser_m, done_l, done_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; bit_period = 8'd1;
    repeat (3) check_idle("reset_held_valid");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_p1();
    accept(8'hA5, 8'd1);
    check_frame("p1_a5", 8'hA5, 1);
    check_idle("p1_after");
  endtask

  task automatic test_p3_zero();
    accept(8'h00, 8'd3);
    check_frame("p3_00", 8'h00, 3);
    check_idle("p3_after");
  endtask

  task automatic test_p0();
    accept(8'hFF, 8'd0);
    check_frame("p0_ff", 8'hFF, 1);
    check_idle("p0_after");
  endtask

  task automatic test_msb();
    accept(8'h80, 8'd2);
    check_frame("p2_80", 8'h80, 2);
    check_idle("p2_after");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_data = 8'h5A; bit_period = 8'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data    = 8'h3C;
    bit_period = 8'd4;
    check_frame("b2b_first", 8'h5A, 2);
    // One idle cycle in which the held word is accepted.
    check_idle("b2b_gap");
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_frame("b2b_second", 8'h3C, 4);
    check_idle("b2b_after");
  endtask

  task automatic test_reset_mid_frame();
    accept(8'hC3, 8'd2);
    // START (2) + data bits 0..3 (8) + first cycle of bit 4.
    repeat (11) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ser_l !== 1'b1 || ser_m !== 1'b1 || done_l !== 1'b0 || done_m !== 1'b0 ||
        in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid async got ser=%b%b done=%b%b ready=%b%b want ser=11 done=00 ready=11",
               ser_l, ser_m, done_l, done_m, in_ready_l, in_ready_m);
    end
    in_valid = 1'b1; in_data = 8'h96; bit_period = 8'd1;
    repeat (2) check_idle("rst_mid_held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_frame("rst_mid_next", 8'h96, 1);
    check_idle("rst_mid_after");
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [DIV_W-1:0]  bp;
    for (int n = 0; n < 20; n++) begin
      d  = DATA_W'($urandom);
      bp = DIV_W'($urandom_range(0, 4));
      accept(d, bp);
      check_frame("random", d, eff_p(bp));
      if ($urandom_range(0, 1) == 1) check_idle("random_gap");
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    bit_period = 8'd1;
    test_reset();
    test_p1();
    test_p3_zero();
    test_p0();
    test_msb();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
